regs_dbg_ctrl: RTL and testbench
================================

Name: regs_dbg_ctrl

Overview:
- Sequences debug (JTAG) accesses to the general-purpose register file's shared debug port.
- Converts a four-phase req/ack debug request into single-cycle write strobes or read samples.
- Detects when an EX writeback to a nonzero register takes the write port, and retries.
- Asserts a pipeline hold when a debug write is starved too long. Sits between the JTAG DM and the register file.

Parameters:
- WAIT_MAX, 8, number of consecutive blocked write cycles before hold_o is raised (1..255).
- CNT_W, 8, width of the blocked-cycle counter.

Ports:
- clk  input  1  system clock
- rst  input  1  reset; asynchronous, active-low
- dbg_req_i  input  1  debug access request (four-phase)
- dbg_we_i  input  1  1=write, 0=read; sampled with request
- dbg_addr_i  input  5  register index; sampled with request
- dbg_wdata_i  input  32  write data; sampled with request
- dbg_ack_o  output  1  access complete
- dbg_rdata_o  output  32  read result, valid while dbg_ack_o=1
- ex_we_i  input  1  EX writeback enable (monitor)
- ex_waddr_i  input  5  EX writeback address (monitor)
- ex_wdata_i  input  32  EX writeback data (monitor)
- rf_we_o  output  1  register-file debug write enable
- rf_addr_o  output  5  register-file debug read/write address
- rf_wdata_o  output  32  register-file debug write data
- rf_rdata_i  input  32  register-file debug read data (combinational from rf_addr_o)
- hold_o  output  1  pipeline hold request
- busy_o  output  1  1 whenever state != IDLE

Behaviour:
- Reset (rst=0, async): state=IDLE; all registered outputs=0; wait_cnt=0; latched addr/data=0.
- Define ex_blk = ex_we_i & (ex_waddr_i != 0). The register file gives EX priority, so a debug write is lost in any cycle where ex_blk=1.
- IDLE:
  - On dbg_req_i=1, latch we/addr/wdata and clear wait_cnt.
  - Go to WR if we=1 and addr!=0.
  - Go to ACK if we=1 and addr=0; the x0 write is dropped and rf_we_o is never asserted.
  - Go to RD if we=0.
- WR:
  - rf_we_o=1 (combinational from state), rf_addr_o/rf_wdata_o = latched values.
  - If ex_blk=0, the write commits at this edge; go to ACK.
  - If ex_blk=1, stay in WR and wait_cnt++ (saturating).
  - hold_o is registered: set on the edge where the incremented wait_cnt reaches WAIT_MAX, cleared on the edge leaving WR.
- RD:
  - rf_addr_o = latched addr, for one cycle.
  - If addr=0, capture 0.
  - Else if ex_we_i=1 and ex_waddr_i=addr, capture ex_wdata_i (bypass the same-cycle writeback).
  - Else capture rf_rdata_i.
  - Capture goes into dbg_rdata_o at the edge; go to ACK.
- ACK:
  - dbg_ack_o=1; dbg_rdata_o holds its value (write: unchanged, previous value).
  - When dbg_req_i=0, go to IDLE and drop dbg_ack_o.
  - No new request is accepted until after one IDLE cycle.
- Latency (unblocked): write req→ack = 2 edges; read = 2 edges.
- Request changes while busy are ignored; only the IDLE-sampled values are used.
- Reset mid-WR: the write is aborted, hold_o drops immediately, and no ack is issued.
- rf_we_o=0 in every state except WR. rf_addr_o=0 in IDLE.

Test Plan:
- Write x5=0xDEADBEEF, ex_we_i=0 → rf_we_o high exactly 1 cycle with addr 5 and that data; dbg_ack_o at cycle 2; after release, busy_o=0.
- Write x0=0x12345678 → rf_we_o never asserts; dbg_ack_o at cycle 1.
- Write x7 with ex_we_i=1, ex_waddr_i=3 for 10 cycles (WAIT_MAX=8) → hold_o rises after 8 blocked cycles; write commits the first cycle ex_blk=0; hold_o falls on that edge; ack follows.
- Write x7 with ex_we_i=1, ex_waddr_i=0 → not blocked; commits in first WR cycle; hold_o stays 0.
- Read x9 with rf_rdata_i=0x55AA55AA, then read x9 while ex_we_i=1, ex_waddr_i=9, ex_wdata_i=0x0BADF00D → dbg_rdata_o=0x55AA55AA, then 0x0BADF00D; read x0 → 0.
- Assert rst=0 during a blocked WR with hold_o=1 → hold_o, rf_we_o, busy_o and dbg_ack_o are 0 immediately (async); state is IDLE after release.

Source files
------------

// File: rtl/regs_dbg_ctrl_if.sv
// Debug request bus between the JTAG DM (master) and the register-file debug sequencer (slave).
// Four-phase req/ack: request fields are held with dbg_req_i until dbg_ack_o rises.
interface regs_dbg_ctrl_if;
   logic        dbg_req_i;
   logic        dbg_we_i;
   logic [4:0]  dbg_addr_i;
   logic [31:0] dbg_wdata_i;
   logic        dbg_ack_o;
   logic [31:0] dbg_rdata_o;

   modport master (
      output dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
      input  dbg_ack_o, dbg_rdata_o
   );

   modport slave (
      input  dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
      output dbg_ack_o, dbg_rdata_o
   );
endinterface

// File: rtl/regs_dbg_ctrl.sv
// Sequences JTAG debug accesses onto the register file's shared debug port,
// retrying writes that lose the port to an EX writeback and raising a pipeline hold when starved.
//
// state | meaning
// IDLE  | waiting for a debug request
// WR    | driving the debug write; retried while EX owns the write port
// RD    | driving the read address; capture result at the edge
// ACK   | dbg_ack_o high until the requester drops dbg_req_i
module regs_dbg_ctrl #(
   parameter int WAIT_MAX = 8,
   parameter int CNT_W    = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   regs_dbg_ctrl_if.slave       dbg,
   input  logic                 ex_we_i,
   input  logic [4:0]           ex_waddr_i,
   input  logic [31:0]          ex_wdata_i,
   output logic                 rf_we_o,
   output logic [4:0]           rf_addr_o,
   output logic [31:0]          rf_wdata_o,
   input  logic [31:0]          rf_rdata_i,
   output logic                 hold_o,
   output logic                 busy_o
);

   typedef enum logic [1:0] {IDLE, WR, RD, ACK} state_t;

   state_t           state;
   logic [4:0]       addr_q;
   logic [31:0]      wdata_q;
   logic [31:0]      rdata_q;
   logic [CNT_W-1:0] wait_cnt;
   logic             hold_q;
   logic             ack_q;

   logic             ex_blk;
   logic [CNT_W-1:0] cnt_inc;
   logic [31:0]      rd_capture;

   assign ex_blk  = ex_we_i & (ex_waddr_i != 5'd0);
   assign cnt_inc = (wait_cnt == '1) ? wait_cnt : wait_cnt + 1'b1;

   // x0 always reads zero; a same-cycle EX writeback to the read address is forwarded
   always_comb begin
      rd_capture = rf_rdata_i;
      if (addr_q == 5'd0)
         rd_capture = 32'd0;
      else if (ex_we_i && (ex_waddr_i == addr_q))
         rd_capture = ex_wdata_i;
   end

   assign rf_we_o         = (state == WR);
   assign rf_addr_o       = ((state == WR) || (state == RD)) ? addr_q : 5'd0;
   assign rf_wdata_o      = (state == WR) ? wdata_q : 32'd0;
   assign busy_o          = (state != IDLE);
   assign hold_o          = hold_q;
   assign dbg.dbg_ack_o   = ack_q;
   assign dbg.dbg_rdata_o = rdata_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         addr_q   <= 5'd0;
         wdata_q  <= 32'd0;
         rdata_q  <= 32'd0;
         wait_cnt <= '0;
         hold_q   <= 1'b0;
         ack_q    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (dbg.dbg_req_i) begin
                  addr_q   <= dbg.dbg_addr_i;
                  wdata_q  <= dbg.dbg_wdata_i;
                  wait_cnt <= '0;
                  if (!dbg.dbg_we_i) begin
                     state <= RD;
                  end else if (dbg.dbg_addr_i != 5'd0) begin
                     state <= WR;
                  end else begin
                     state <= ACK;
                     ack_q <= 1'b1;
                  end
               end
            end
            WR: begin
               if (!ex_blk) begin
                  state  <= ACK;
                  ack_q  <= 1'b1;
                  hold_q <= 1'b0;
               end else begin
                  wait_cnt <= cnt_inc;
                  if (cnt_inc >= CNT_W'(WAIT_MAX))
                     hold_q <= 1'b1;
               end
            end
            RD: begin
               rdata_q <= rd_capture;
               state   <= ACK;
               ack_q   <= 1'b1;
            end
            ACK: begin
               if (!dbg.dbg_req_i) begin
                  state <= IDLE;
                  ack_q <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               ack_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_regs_dbg_ctrl.sv
// Scoreboard bench for regs_dbg_ctrl: expected acks and register-file commits are queued
// when a request is driven and compared when the DUT acks or strobes the write port.
module tb_regs_dbg_ctrl;

   typedef struct {
      string       tag;
      logic [31:0] rdata;
      int          lat;
   } ack_exp_t;

   typedef struct {
      logic [4:0]  addr;
      logic [31:0] data;
   } wr_exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        ex_we_i = 1'b0;
   logic [4:0]  ex_waddr_i = 5'd0;
   logic [31:0] ex_wdata_i = 32'd0;
   logic        rf_we_o;
   logic [4:0]  rf_addr_o;
   logic [31:0] rf_wdata_o;
   logic [31:0] rf_rdata_i;
   logic        hold_o;
   logic        busy_o;

   regs_dbg_ctrl_if dbg ();

   regs_dbg_ctrl #(.WAIT_MAX(8), .CNT_W(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .dbg        (dbg.slave),
      .ex_we_i    (ex_we_i),
      .ex_waddr_i (ex_waddr_i),
      .ex_wdata_i (ex_wdata_i),
      .rf_we_o    (rf_we_o),
      .rf_addr_o  (rf_addr_o),
      .rf_wdata_o (rf_wdata_o),
      .rf_rdata_i (rf_rdata_i),
      .hold_o     (hold_o),
      .busy_o     (busy_o)
   );

   always #5 clk = ~clk;

   logic [31:0] rf_mem [32];
   assign rf_rdata_i = rf_mem[rf_addr_o];

   ack_exp_t    ack_q [$];
   wr_exp_t     wr_q  [$];
   int          n_chk = 0;
   int          n_pass = 0;
   int          edge_cnt = 0;
   int          start_edge = 0;
   int          we_cycles = 0;
   logic        hold_seen = 1'b0;
   logic        ack_prev = 1'b0;
   logic [31:0] rd_model = 32'd0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   always @(posedge clk) edge_cnt++;

   // ack and write-port monitors, sampled mid-cycle
   always @(negedge clk) begin
      if (rst) begin
         if (rf_we_o) begin
            we_cycles++;
            if (!(ex_we_i && ex_waddr_i != 5'd0)) begin
               if (wr_q.size() == 0) begin
                  chk("wr_unexpected", rf_we_o, 1'b0);
               end else begin
                  wr_exp_t w;
                  w = wr_q.pop_front();
                  chk("wr_addr", rf_addr_o, w.addr);
                  chk("wr_data", rf_wdata_o, w.data);
                  rf_mem[rf_addr_o] = rf_wdata_o;
               end
            end
         end
         if (hold_o) hold_seen = 1'b1;
         if (dbg.dbg_ack_o && !ack_prev) begin
            if (ack_q.size() == 0) begin
               chk("ack_unexpected", dbg.dbg_ack_o, 1'b0);
            end else begin
               ack_exp_t a;
               a = ack_q.pop_front();
               chk({a.tag, "_rdata"}, dbg.dbg_rdata_o, a.rdata);
               chk({a.tag, "_lat"}, edge_cnt - start_edge, a.lat);
            end
         end
         ack_prev = dbg.dbg_ack_o;
      end else begin
         ack_prev = 1'b0;
      end
   end

   task automatic start_req(input logic we, input logic [4:0] addr, input logic [31:0] wdata,
                            input logic [31:0] exp_rd, input int lat, input string tag);
      ack_exp_t a;
      a.tag = tag; a.rdata = exp_rd; a.lat = lat;
      ack_q.push_back(a);
      if (we && addr != 5'd0) wr_q.push_back('{addr: addr, data: wdata});
      if (!we) rd_model = exp_rd;
      @(posedge clk); #1;
      dbg.dbg_req_i   = 1'b1;
      dbg.dbg_we_i    = we;
      dbg.dbg_addr_i  = addr;
      dbg.dbg_wdata_i = wdata;
      start_edge = edge_cnt;
      we_cycles  = 0;
      hold_seen  = 1'b0;
   endtask

   task automatic wait_ack(input string tag);
      int n = 0;
      while (!dbg.dbg_ack_o && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      chk({tag, "_ack_seen"}, dbg.dbg_ack_o, 1'b1);
   endtask

   task automatic release_req(input string tag);
      dbg.dbg_req_i   = 1'b0;
      dbg.dbg_addr_i  = 5'h1f;
      dbg.dbg_wdata_i = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      chk({tag, "_busy_rel"}, busy_o, 1'b0);
      chk({tag, "_ack_rel"}, dbg.dbg_ack_o, 1'b0);
   endtask

   task automatic access(input logic we, input logic [4:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rd, input int lat, input string tag);
      start_req(we, addr, wdata, exp_rd, lat, tag);
      wait_ack(tag);
      release_req(tag);
   endtask

   initial begin
      for (int i = 0; i < 32; i++) rf_mem[i] = 32'hA000_0000 | i;
      rf_mem[0] = 32'd0;
      rf_mem[9] = 32'h55AA_55AA;
      dbg.dbg_req_i = 1'b0; dbg.dbg_we_i = 1'b0;
      dbg.dbg_addr_i = 5'd0; dbg.dbg_wdata_i = 32'd0;

      #12;
      chk("rst_ack", dbg.dbg_ack_o, 1'b0);
      chk("rst_busy", busy_o, 1'b0);
      chk("rst_we", rf_we_o, 1'b0);
      chk("rst_hold", hold_o, 1'b0);
      chk("rst_rdata", dbg.dbg_rdata_o, 32'd0);
      chk("rst_addr", rf_addr_o, 5'd0);
      rst = 1'b1;

      access(1'b1, 5'd5, 32'hDEAD_BEEF, rd_model, 2, "wr_x5");
      chk("wr_x5_we_cycles", we_cycles, 1);

      access(1'b1, 5'd0, 32'h1234_5678, rd_model, 1, "wr_x0");
      chk("wr_x0_we_cycles", we_cycles, 0);

      access(1'b0, 5'd5, 32'd0, 32'hDEAD_BEEF, 2, "rd_x5");

      // write starved by EX writeback to x3 for 10 cycles
      ex_we_i = 1'b1; ex_waddr_i = 5'd3; ex_wdata_i = 32'h3333_3333;
      start_req(1'b1, 5'd7, 32'hCAFE_0007, rd_model, 12, "wr_blk");
      @(posedge clk); #1;
      for (int i = 1; i <= 10; i++) begin
         @(posedge clk); #1;
         chk($sformatf("blk_hold_%0d", i), hold_o, (i >= 8) ? 1'b1 : 1'b0);
         chk($sformatf("blk_we_%0d", i), rf_we_o, 1'b1);
      end
      ex_we_i = 1'b0;
      @(posedge clk); #1;
      chk("blk_hold_fall", hold_o, 1'b0);
      chk("blk_ack", dbg.dbg_ack_o, 1'b1);
      release_req("wr_blk");

      // EX writeback to x0 does not block
      ex_we_i = 1'b1; ex_waddr_i = 5'd0; ex_wdata_i = 32'h9999_9999;
      access(1'b1, 5'd7, 32'h7777_0007, rd_model, 2, "wr_x7_ex0");
      chk("wr_x7_ex0_we_cycles", we_cycles, 1);
      chk("wr_x7_ex0_hold", hold_seen, 1'b0);
      ex_we_i = 1'b0;

      access(1'b0, 5'd9, 32'd0, 32'h55AA_55AA, 2, "rd_x9");
      ex_we_i = 1'b1; ex_waddr_i = 5'd9; ex_wdata_i = 32'h0BAD_F00D;
      access(1'b0, 5'd9, 32'd0, 32'h0BAD_F00D, 2, "rd_x9_byp");
      ex_waddr_i = 5'd0; ex_wdata_i = 32'hFFFF_FFFF;
      access(1'b0, 5'd0, 32'd0, 32'd0, 2, "rd_x0");
      ex_we_i = 1'b0;
      access(1'b0, 5'd7, 32'd0, 32'h7777_0007, 2, "rd_x7");

      // async reset during a starved write
      ex_we_i = 1'b1; ex_waddr_i = 5'd4;
      @(posedge clk); #1;
      dbg.dbg_req_i = 1'b1; dbg.dbg_we_i = 1'b1;
      dbg.dbg_addr_i = 5'd12; dbg.dbg_wdata_i = 32'h1212_1212;
      repeat (10) begin @(posedge clk); #1; end
      chk("rst_mid_hold_pre", hold_o, 1'b1);
      #2 rst = 1'b0;
      #1;
      chk("rst_mid_hold", hold_o, 1'b0);
      chk("rst_mid_we", rf_we_o, 1'b0);
      chk("rst_mid_busy", busy_o, 1'b0);
      chk("rst_mid_ack", dbg.dbg_ack_o, 1'b0);
      dbg.dbg_req_i = 1'b0; ex_we_i = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (2) begin @(posedge clk); #1; end
      chk("rst_rel_busy", busy_o, 1'b0);
      chk("rst_rel_ack", dbg.dbg_ack_o, 1'b0);
      chk("rst_abort_mem", rf_mem[12], 32'hA000_000C);

      access(1'b0, 5'd5, 32'd0, 32'hDEAD_BEEF, 2, "rd_after_rst");

      chk("ack_q_drained", ack_q.size(), 0);
      chk("wr_q_drained", wr_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
